// File: rtl/iadc_pkg.sv
// Shared types and defaults for the iadc sample scheduler.
package iadc_pkg;

    localparam int NCH_DEF = 4;
    localparam int DW_DEF  = 8;
    localparam int PLW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_e;

    // Saturating add for the 8-bit overrun counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input int unsigned b);
        int unsigned s;
        s = int'(a) + b;
        return (s > 255) ? 8'hFF : 8'(s);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic           gnt_vld,
    output logic [CW-1:0]  gnt_idx
);

    // Scan offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NCH;
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/iadc_sched.sv
// Captures per-channel iadc samples, round-robins them onto a valid/ready
// stream and sequences one triggered acquisition.
module iadc_sched
    import iadc_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int DW  = DW_DEF,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int PLW = PLW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*DW-1:0] ch_q,
    input  logic [NCH-1:0]    ch_wr,
    input  logic [NCH-1:0]    en_mask,
    input  logic              arm,
    input  logic              abort,
    input  logic [DW-1:0]     thresh,
    input  logic [PLW-1:0]    post_len,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [CW-1:0]     m_ch,
    output logic              m_post,
    output logic [CW-1:0]     trig_ch,
    output logic [7:0]        ovf_cnt,
    output logic [2:0]        state,
    output logic              done
);

    sched_state_e   r_state;
    sched_state_e   w_state_nxt;

    logic [DW-1:0]  r_hold [NCH];
    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] r_post;

    logic           r_m_valid;
    logic [DW-1:0]  r_m_data;
    logic [CW-1:0]  r_m_ch;
    logic           r_m_post;

    logic [CW-1:0]  r_rr_ptr;
    logic [CW-1:0]  r_trig_ch;
    logic [7:0]     r_ovf_cnt;
    logic [PLW-1:0] r_post_len;
    logic [PLW-1:0] r_post_cnt;

    logic           w_cap_en;
    logic [NCH-1:0] w_cap;
    logic           w_hs;
    logic           w_slot_free;
    logic           w_gnt_vld;
    logic [CW-1:0]  w_gnt_idx;
    logic           w_load;
    logic [NCH-1:0] w_gnt_oh;
    logic [CW-1:0]  w_ptr_nxt;
    logic           w_trig;
    logic [CW-1:0]  w_trig_idx;
    int unsigned    w_ovf_n;
    logic           w_arm_ok;

    rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
        .req     (r_pend),
        .ptr     (r_rr_ptr),
        .gnt_vld (w_gnt_vld),
        .gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_cap_en    = (r_state == ARMED) || (r_state == RUN);
        w_hs        = r_m_valid & m_ready;
        w_slot_free = !r_m_valid || w_hs;
        w_load      = w_slot_free & w_gnt_vld;
        w_gnt_oh    = w_load ? (NCH'(1) << w_gnt_idx) : '0;
        w_ptr_nxt   = (w_gnt_idx == CW'(NCH - 1)) ? '0 : w_gnt_idx + CW'(1);
        w_arm_ok    = arm & !abort & ((r_state == IDLE) || (r_state == DONE));
    end

    // Capture strobes, overrun count and trigger detection; descending scan
    // leaves the lowest triggering channel in w_trig_idx.
    always_comb begin
        w_cap      = '0;
        w_trig     = 1'b0;
        w_trig_idx = '0;
        w_ovf_n    = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            w_cap[i] = ch_wr[i] & en_mask[i] & w_cap_en;
            if (w_cap[i] && r_pend[i] && !w_gnt_oh[i]) begin
                w_ovf_n = w_ovf_n + 1;
            end
            if (w_cap[i] && (ch_q[i*DW +: DW] >= thresh)) begin
                w_trig     = 1'b1;
                w_trig_idx = CW'(i);
            end
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (arm) w_state_nxt = ARMED;
            ARMED:   if (w_trig) w_state_nxt = RUN;
            RUN:     if (r_post_cnt == r_post_len) w_state_nxt = DRAIN;
            DRAIN:   if ((r_pend == '0) && !r_m_valid) w_state_nxt = DONE;
            DONE:    if (arm) w_state_nxt = ARMED;
            default: w_state_nxt = IDLE;
        endcase
        if (abort) begin
            w_state_nxt = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the sample holding registers are reset too; pend[] alone would
    // suffice, but it keeps m_data deterministic after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            r_post <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (abort) begin
                    r_pend[i] <= 1'b0;
                end else if (w_cap[i]) begin
                    r_hold[i] <= ch_q[i*DW +: DW];
                    r_pend[i] <= 1'b1;
                    r_post[i] <= (r_state == RUN);
                end else if (w_gnt_oh[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_ch    <= '0;
            r_m_post  <= 1'b0;
            r_rr_ptr  <= '0;
        end else if (abort) begin
            r_m_valid <= 1'b0;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_hold[w_gnt_idx];
            r_m_ch    <= w_gnt_idx;
            r_m_post  <= r_post[w_gnt_idx];
            r_rr_ptr  <= w_ptr_nxt;
        end else if (w_hs) begin
            r_m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_cnt  <= '0;
            r_post_cnt <= '0;
            r_post_len <= '0;
            r_trig_ch  <= '0;
        end else begin
            if (w_arm_ok) begin
                r_ovf_cnt <= '0;
            end else if (w_ovf_n != 0) begin
                r_ovf_cnt <= sat_add8(r_ovf_cnt, w_ovf_n);
            end

            if (w_arm_ok) begin
                r_post_cnt <= '0;
            end else if ((r_state == RUN) && w_hs && r_m_post) begin
                r_post_cnt <= r_post_cnt + PLW'(1);
            end

            if ((r_state == ARMED) && w_trig && !abort) begin
                r_trig_ch  <= w_trig_idx;
                r_post_len <= post_len;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_ch    = r_m_ch;
    assign m_post  = r_m_post;
    assign trig_ch = r_trig_ch;
    assign ovf_cnt = r_ovf_cnt;
    assign state   = r_state;
    assign done    = (r_state == DONE);

endmodule

// File: tb/tb_iadc_sched.sv
// Directed bench for iadc_sched: reset, trigger, round-robin, overrun, masking, abort.
module tb_iadc_sched;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 2;
    localparam int PLW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*DW-1:0] ch_q;
    logic [NCH-1:0]    ch_wr;
    logic [NCH-1:0]    en_mask;
    logic              arm;
    logic              abort;
    logic [DW-1:0]     thresh;
    logic [PLW-1:0]    post_len;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [CW-1:0]     m_ch;
    logic              m_post;
    logic [CW-1:0]     trig_ch;
    logic [7:0]        ovf_cnt;
    logic [2:0]        state;
    logic              done;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    iadc_sched #(.NCH(NCH), .DW(DW), .CW(CW), .PLW(PLW)) dut (
        .clk      (clk),
        .reset    (reset),
        .ch_q     (ch_q),
        .ch_wr    (ch_wr),
        .en_mask  (en_mask),
        .arm      (arm),
        .abort    (abort),
        .thresh   (thresh),
        .post_len (post_len),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_ch     (m_ch),
        .m_post   (m_post),
        .trig_ch  (trig_ch),
        .ovf_cnt  (ovf_cnt),
        .state    (state),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr1(input int ch, input logic [7:0] q);
        ch_q[ch*DW +: DW] = q;
        ch_wr             = '0;
        ch_wr[ch]         = 1'b1;
        tick();
        ch_wr             = '0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [7:0] d, input logic [1:0] c, input logic p);
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_data"},  32'(m_data),  32'(d));
        check({tag, "_ch"},    32'(m_ch),    32'(c));
        check({tag, "_post"},  32'(m_post),  32'(p));
    endtask

    initial begin
        reset    = 1'b1;
        ch_q     = '0;
        ch_wr    = '0;
        en_mask  = 4'hF;
        arm      = 1'b0;
        abort    = 1'b0;
        thresh   = 8'h80;
        post_len = 16'd3;
        m_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_state", 32'(state),   32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_done",  32'(done),    32'd0);
        check("rst_ovf",   32'(ovf_cnt), 32'd0);

        // Pre-trigger sample then a triggering sample on ch2.
        m_ready = 1'b1;
        pulse_arm();
        check("t2_armed", 32'(state), 32'd1);
        wr1(0, 8'h10);
        tick();
        check_beat("t2_b0", 8'h10, 2'd0, 1'b0);
        wr1(2, 8'h90);
        check("t2_run",  32'(state),   32'd2);
        check("t2_trig", 32'(trig_ch), 32'd2);
        tick();
        check_beat("t2_b1", 8'h90, 2'd2, 1'b0);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t2_abort_state", 32'(state),   32'd0);
        check("t2_abort_valid", 32'(m_valid), 32'd0);

        // Fresh acquisition: trigger on ch3 so the pointer wraps to 0.
        pulse_arm();
        wr1(3, 8'hA0);
        check("t3_run",  32'(state),   32'd2);
        check("t3_trig", 32'(trig_ch), 32'd3);
        tick();
        check_beat("t3_trigbeat", 8'hA0, 2'd3, 1'b0);
        ch_q  = {8'h04, 8'h03, 8'h02, 8'h01};
        ch_wr = 4'hF;
        tick();
        ch_wr = '0;
        check("t3_gap", 32'(m_valid), 32'd0);
        tick();
        check_beat("t3_p0", 8'h01, 2'd0, 1'b1);
        tick();
        check_beat("t3_p1", 8'h02, 2'd1, 1'b1);
        tick();
        check_beat("t3_p2", 8'h03, 2'd2, 1'b1);
        ch_q  = {8'h14, 8'h13, 8'h12, 8'h11};
        ch_wr = 4'hF;
        tick();
        ch_wr = '0;
        check_beat("t3_p3", 8'h04, 2'd3, 1'b1);
        check("t3_no_ovf", 32'(ovf_cnt), 32'd0);
        tick();
        check("t3_drain", 32'(state), 32'd3);
        check_beat("t3_d0", 8'h11, 2'd0, 1'b1);
        tick();
        check_beat("t3_d1", 8'h12, 2'd1, 1'b1);
        tick();
        check_beat("t3_d2", 8'h13, 2'd2, 1'b1);
        tick();
        check_beat("t3_d3", 8'h14, 2'd3, 1'b1);
        tick();
        check("t3_empty",       32'(m_valid), 32'd0);
        check("t3_still_drain", 32'(state),   32'd3);
        tick();
        check("t3_done_state", 32'(state), 32'd4);
        check("t3_done",       32'(done),  32'd1);

        // Overrun: slot blocked by ch0, ch1 written three times.
        m_ready = 1'b0;
        pulse_arm();
        check("t4_armed", 32'(state), 32'd1);
        check("t4_done0", 32'(done),  32'd0);
        wr1(0, 8'h05);
        tick();
        wr1(1, 8'h21);
        wr1(1, 8'h22);
        wr1(1, 8'h23);
        check("t4_ovf2", 32'(ovf_cnt), 32'd2);
        check_beat("t4_stall", 8'h05, 2'd0, 1'b0);
        m_ready = 1'b1;
        tick();
        check_beat("t4_last", 8'h23, 2'd1, 1'b0);
        tick();
        check("t4_one_beat", 32'(m_valid), 32'd0);

        m_ready  = 1'b0;
        ch_q[15:8] = 8'h30;
        ch_wr    = 4'b0010;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        ch_wr = '0;
        check("t4_ovf_sat", 32'(ovf_cnt), 32'd255);

        // Masked channel cannot capture or trigger; ch3 triggers.
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t5_flushed", 32'(m_valid), 32'd0);
        en_mask = 4'b1110;
        wr1(0, 8'hFF);
        tick();
        tick();
        check("t5_masked_valid", 32'(m_valid), 32'd0);
        check("t5_masked_state", 32'(state),   32'd1);
        m_ready = 1'b0;
        wr1(3, 8'hFF);
        check("t5_run",  32'(state),   32'd2);
        check("t5_trig", 32'(trig_ch), 32'd3);
        tick();
        check_beat("t5_beat", 8'hFF, 2'd3, 1'b0);

        // Asynchronous reset in RUN with a beat pending.
        reset = 1'b1;
        tick();
        check("t1_state", 32'(state),   32'd0);
        check("t1_valid", 32'(m_valid), 32'd0);
        check("t1_data",  32'(m_data),  32'd0);
        check("t1_ch",    32'(m_ch),    32'd0);
        check("t1_post",  32'(m_post),  32'd0);
        check("t1_trig",  32'(trig_ch), 32'd0);
        check("t1_ovf",   32'(ovf_cnt), 32'd0);
        check("t1_done",  32'(done),    32'd0);
        reset = 1'b0;
        tick();

        // Abort beats a simultaneous arm.
        en_mask  = 4'hF;
        post_len = 16'd3;
        pulse_arm();
        wr1(2, 8'h90);
        tick();
        check("t6_valid_run", 32'(m_valid), 32'd1);
        check("t6_run",       32'(state),   32'd2);
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        check("t6_abort_state", 32'(state),   32'd0);
        check("t6_abort_valid", 32'(m_valid), 32'd0);
        check("t6_abort_done",  32'(done),    32'd0);

        // post_len=0, trigger exactly at threshold.
        post_len = 16'd0;
        m_ready  = 1'b1;
        pulse_arm();
        wr1(1, 8'h80);
        check("t6_run0", 32'(state), 32'd2);
        tick();
        check("t6_drain0", 32'(state), 32'd3);
        check_beat("t6_beat", 8'h80, 2'd1, 1'b0);
        tick();
        check("t6_drain1", 32'(state),   32'd3);
        check("t6_empty",  32'(m_valid), 32'd0);
        tick();
        check("t6_done_state", 32'(state), 32'd4);
        check("t6_done",       32'(done),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
